tx_pattern_gen: RTL and testbench

- Parametrised TX test-pattern source in the radio_clk domain.
- Drives the 32-bit-style I/Q TX sample bus with a selectable pattern while run_tx is high, and passes tx_idle through otherwise.
- Generalises the fixed 2-cycle square-wave generator with programmable width, period, amplitude, pattern mode and burst length.

---
 rtl/tx_pattern_gen_pkg.sv | 20 ++
 rtl/tx_pattern_gen_prbs.sv | 26 ++
 rtl/tx_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_tx_pattern_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pattern_gen_pkg.sv
// Shared constants for the TX test-pattern source: pattern modes, FSM states, PRBS-15 seed and taps.
package tx_pattern_pkg;

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;
  localparam logic [1:0] MODE_PRBS   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } tx_state_e;

  // x^15 + x^14 + 1: feedback is the XOR of state bits 14 and 13.
  localparam logic [14:0] PRBS15_SEED  = 15'h7FFF;
  localparam int          PRBS15_TAP_A = 14;
  localparam int          PRBS15_TAP_B = 13;

endpackage

// File: rtl/tx_pattern_gen_prbs.sv
// 15-bit PRBS-15 LFSR with sync reset, seed load and advance enable; exposes the two low state bits.
module tx_prbs15
  import tx_pattern_pkg::*;
(
  input  logic       radio_clk,
  input  logic       radio_rst,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] prbs_bits
);

  logic [14:0] lfsr;

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      lfsr <= PRBS15_SEED;
    end else if (load) begin
      lfsr <= PRBS15_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[13:0], lfsr[PRBS15_TAP_A] ^ lfsr[PRBS15_TAP_B]};
    end
  end

  assign prbs_bits = lfsr[1:0];

endmodule

// File: rtl/tx_pattern_gen.sv
// TX test-pattern source: emits SQUARE/RAMP/CONST/PRBS {I,Q} samples while run_tx is high, else passes tx_idle.
// Build option: TX_PATTERN_GEN_PRBS_EN instantiates the LFSR; without it mode 3 behaves as CONST.
// Handshake: run_tx is a level request; config is captured only on the IDLE->RUN edge, and after a
// finished burst the block sits in HOLD until run_tx has been low for at least one cycle.
module tx_pattern_gen
  import tx_pattern_pkg::*;
#(
  parameter int SAMP_W  = 16,
  parameter int HALF_W  = 8,
  parameter int BURST_W = 16
) (
  input  logic                  radio_clk,
  input  logic                  radio_rst,
  input  logic                  run_tx,
  input  logic [2*SAMP_W-1:0]   tx_idle,
  input  logic [1:0]            mode,
  input  logic [HALF_W-1:0]     half_period,
  input  logic [SAMP_W-1:0]     amplitude,
  input  logic [BURST_W-1:0]    burst_len,
  output logic [2*SAMP_W-1:0]   tx,
  output logic                  pattern_active,
  output logic                  burst_done,
  output tx_state_e             state_dbg
);

  tx_state_e            state;
  logic [1:0]           mode_q;
  logic [HALF_W-1:0]    half_q;
  logic [SAMP_W-1:0]    amp_q;
  logic [BURST_W-1:0]   burst_q;
  logic [BURST_W-1:0]   sample_cnt;
  logic [SAMP_W-1:0]    ramp_cnt;
  logic [HALF_W-1:0]    phase_cnt;
  logic                 sq_hi;

  logic [HALF_W-1:0]    half_eff;
  logic                 last_sample;
  logic [SAMP_W-1:0]    samp_i;
  logic [SAMP_W-1:0]    samp_q;

  assign state_dbg   = state;
  assign half_eff    = (half_q == '0) ? HALF_W'(1) : half_q;
  assign last_sample = (burst_q != '0) && (sample_cnt == burst_q - 1'b1);

`ifdef TX_PATTERN_GEN_PRBS_EN
  logic [1:0]        prbs_bits;
  logic [SAMP_W-1:0] neg_amp;

  assign neg_amp = '0 - amp_q;

  tx_prbs15 u_prbs (
    .radio_clk (radio_clk),
    .radio_rst (radio_rst),
    .load      ((state == IDLE) && run_tx),
    .advance   ((state == RUN) && run_tx),
    .prbs_bits (prbs_bits)
  );
`endif

  always_comb begin
    samp_i = amp_q;
    samp_q = amp_q;
    case (mode_q)
      MODE_SQUARE: begin
        samp_i = sq_hi ? amp_q : '0;
        samp_q = sq_hi ? amp_q : '0;
      end
      MODE_RAMP: begin
        samp_i = ramp_cnt;
        samp_q = ~ramp_cnt;
      end
`ifdef TX_PATTERN_GEN_PRBS_EN
      MODE_PRBS: begin
        samp_i = prbs_bits[0] ? amp_q : neg_amp;
        samp_q = prbs_bits[1] ? amp_q : neg_amp;
      end
`endif
      default: begin
        samp_i = amp_q;
        samp_q = amp_q;
      end
    endcase
  end

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      state          <= IDLE;
      tx             <= '0;
      pattern_active <= 1'b0;
      burst_done     <= 1'b0;
      mode_q         <= '0;
      half_q         <= '0;
      amp_q          <= '0;
      burst_q        <= '0;
      sample_cnt     <= '0;
      ramp_cnt       <= '0;
      phase_cnt      <= '0;
      sq_hi          <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          tx             <= tx_idle;
          pattern_active <= 1'b0;
          if (run_tx) begin
            mode_q     <= mode;
            half_q     <= half_period;
            amp_q      <= amplitude;
            burst_q    <= burst_len;
            sample_cnt <= '0;
            ramp_cnt   <= '0;
            phase_cnt  <= '0;
            sq_hi      <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          // The last burst index still pulses burst_done even if run_tx drops on that edge.
          if (last_sample) burst_done <= 1'b1;
          if (!run_tx) begin
            tx             <= tx_idle;
            pattern_active <= 1'b0;
            state          <= IDLE;
          end else begin
            tx             <= {samp_i, samp_q};
            pattern_active <= 1'b1;
            if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
            ramp_cnt <= ramp_cnt + 1'b1;
            if (phase_cnt == half_eff - 1'b1) begin
              phase_cnt <= '0;
              sq_hi     <= ~sq_hi;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
            state <= last_sample ? HOLD : RUN;
          end
        end
        HOLD: begin
          tx             <= tx_idle;
          pattern_active <= 1'b0;
          if (!run_tx) state <= IDLE;
        end
        default: begin
          tx             <= tx_idle;
          pattern_active <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Scoreboard bench for tx_pattern_gen: a per-cycle reference model pushes expected {tx,pattern_active,burst_done}.
module tb_tx_pattern_gen;
  import tx_pattern_pkg::*;

  localparam int SAMP_W  = 16;
  localparam int HALF_W  = 8;
  localparam int BURST_W = 16;
  localparam int TX_W    = 2 * SAMP_W;
  localparam int TAB_N   = 1024;

  logic                radio_clk;
  logic                radio_rst;
  logic                run_tx;
  logic [TX_W-1:0]     tx_idle;
  logic [1:0]          mode;
  logic [HALF_W-1:0]   half_period;
  logic [SAMP_W-1:0]   amplitude;
  logic [BURST_W-1:0]  burst_len;
  logic [TX_W-1:0]     tx;
  logic                pattern_active;
  logic                burst_done;
  tx_state_e           state_dbg;

  tx_pattern_gen #(.SAMP_W(SAMP_W), .HALF_W(HALF_W), .BURST_W(BURST_W)) dut (
    .radio_clk      (radio_clk),
    .radio_rst      (radio_rst),
    .run_tx         (run_tx),
    .tx_idle        (tx_idle),
    .mode           (mode),
    .half_period    (half_period),
    .amplitude      (amplitude),
    .burst_len      (burst_len),
    .tx             (tx),
    .pattern_active (pattern_active),
    .burst_done     (burst_done),
    .state_dbg      (state_dbg)
  );

  // clock / reset block
  initial radio_clk = 1'b0;
  always #5 radio_clk = ~radio_clk;

  // scoreboard
  logic [TX_W+1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // reference model: session phase, sample index, latched configuration
  int               m_phase;   // 0 waiting, 1 emitting, 2 burst finished
  int               m_k;
  logic [1:0]       m_mode;
  int               m_half;
  logic [SAMP_W-1:0] m_amp;
  int               m_bl;
  logic [14:0]      prbs_tab[TAB_N];

  function automatic logic [TX_W-1:0] model_sample(int kk);
    int h;
    logic [SAMP_W-1:0] a, na, i, q;
    logic [14:0] st;
    h  = (m_half == 0) ? 1 : m_half;
    a  = m_amp;
    na = SAMP_W'(0) - m_amp;
    st = prbs_tab[kk % TAB_N];
    i = a;
    q = a;
    case (m_mode)
      2'd0: begin
        i = (((kk / h) % 2) == 1) ? a : '0;
        q = i;
      end
      2'd1: begin
        i = SAMP_W'(kk);
        q = ~i;
      end
      2'd3: begin
`ifdef TX_PATTERN_GEN_PRBS_EN
        i = st[0] ? a : na;
        q = st[1] ? a : na;
`else
        i = a;
        q = a;
`endif
      end
      default: begin
        i = a;
        q = a;
      end
    endcase
    return {i, q};
  endfunction

  // driver: apply one cycle of inputs, push the expected post-edge outputs
  task automatic step(input logic r, input logic run, input logic [TX_W-1:0] idle);
    logic [TX_W+1:0] e;
    logic last;
    radio_rst = r;
    run_tx    = run;
    tx_idle   = idle;
    e = '0;
    if (r) begin
      e = '0;
      m_phase = 0;
      m_k = 0;
    end else if (m_phase == 0) begin
      e = {idle, 2'b00};
      if (run) begin
        m_mode = mode;
        m_half = int'(half_period);
        m_amp  = amplitude;
        m_bl   = int'(burst_len);
        m_k    = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      last = (m_bl != 0) && (m_k == m_bl - 1);
      if (!run) begin
        e = {idle, 1'b0, last};
        m_phase = 0;
      end else begin
        e = {model_sample(m_k), 1'b1, last};
        m_k = m_k + 1;
        m_phase = last ? 2 : 1;
      end
    end else begin
      e = {idle, 2'b00};
      if (!run) m_phase = 0;
    end
    exp_q.push_back(e);
    @(posedge radio_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] md, input int h, input logic [SAMP_W-1:0] a, input int bl);
    mode        = md;
    half_period = HALF_W'(h);
    amplitude   = a;
    burst_len   = BURST_W'(bl);
  endtask

  task automatic run_cycles(input logic run, input int n);
    for (int i = 0; i < n; i++) step(1'b0, run, TX_W'($urandom));
  endtask

  // monitor
  always @(negedge radio_clk) begin
    logic [TX_W+1:0] e;
    logic [TX_W+1:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {tx, pattern_active, burst_done};
      checks++;
      if (got === e) passes++;
      else $display("FAIL cycle_out @%0t: got tx=%h pa=%b bd=%b, expected tx=%h pa=%b bd=%b",
                    $time, got[TX_W+1:2], got[1], got[0], e[TX_W+1:2], e[1], e[0]);
    end
  end

  initial begin
    prbs_tab[0] = 15'h7FFF;
    for (int i = 1; i < TAB_N; i++) begin
      logic [14:0] p;
      p = prbs_tab[i-1];
      prbs_tab[i] = {p[13:0], p[14] ^ p[13]};
    end
    m_phase = 0;
    m_k = 0;
    m_mode = '0;
    m_half = 0;
    m_amp = '0;
    m_bl = 0;
    radio_rst = 1'b1;
    run_tx = 1'b0;
    tx_idle = '0;
    set_cfg(2'd2, 1, 16'h0100, 0);

    // reset with run_tx high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h12345678);
    step(1'b0, 1'b1, 32'h12345678);
    run_cycles(1'b1, 4);
    run_cycles(1'b0, 2);

    // square continuous H=2, then H=0
    set_cfg(2'd0, 2, 16'hAAAA, 0);
    run_cycles(1'b1, 13);
    run_cycles(1'b0, 2);
    set_cfg(2'd0, 0, 16'hAAAA, 0);
    run_cycles(1'b1, 9);
    run_cycles(1'b0, 2);

    // const burst of 3, HOLD while run stays high, then re-trigger
    set_cfg(2'd2, 1, 16'h0100, 3);
    run_cycles(1'b1, 8);
    run_cycles(1'b0, 1);
    run_cycles(1'b1, 6);
    run_cycles(1'b0, 2);

    // ramp aborted after k=5, then restarted
    set_cfg(2'd1, 1, 16'h0000, 0);
    run_cycles(1'b1, 7);
    run_cycles(1'b0, 2);
    run_cycles(1'b1, 5);
    run_cycles(1'b0, 2);

    // PRBS, unit and most-negative amplitude
    set_cfg(2'd3, 1, 16'h0001, 0);
    run_cycles(1'b1, 41);
    run_cycles(1'b0, 2);
    set_cfg(2'd3, 1, 16'h8000, 0);
    run_cycles(1'b1, 10);
    run_cycles(1'b0, 1);

    // burst of one
    set_cfg(2'd2, 1, 16'h5A5A, 1);
    run_cycles(1'b1, 3);
    run_cycles(1'b0, 2);

    // randomized sessions, config disturbed mid-run, occasional reset
    for (int s = 0; s < 60; s++) begin
      int rl;
      int gap;
      set_cfg(2'($urandom_range(0, 3)), $urandom_range(0, 5),
              ($urandom_range(0, 7) == 0) ? 16'h8000 : SAMP_W'($urandom),
              $urandom_range(0, 6));
      rl  = $urandom_range(1, 25);
      gap = $urandom_range(1, 3);
      for (int j = 0; j < rl; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0)
          set_cfg(2'($urandom_range(0, 3)), $urandom_range(0, 5), SAMP_W'($urandom), $urandom_range(0, 6));
        step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, 1'b1, TX_W'($urandom));
      end
      run_cycles(1'b0, gap);
    end

    @(negedge radio_clk);
    @(negedge radio_clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
